// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass and load-use bubble insertion; optional bypass via ID_EX_WB_BYPASS_EN.
// Latency: one cycle from capturing edge to ex_* outputs; load_use_stall is combinational.
// Backpressure: hold freezes the stage; load_use_stall asks IF and IF/ID to hold while a bubble is issued.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module id_ex_stage #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int CTRL_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [4:0]            id_rs,
  input  logic [4:0]            id_rt,
  input  logic [4:0]            id_rd,
  input  logic [DATA_WIDTH-1:0] id_rdata1,
  input  logic [DATA_WIDTH-1:0] id_rdata2,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic                  wb_reg_write,
  input  logic [4:0]            wb_we,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  load_use_stall,
  output logic                  ex_valid,
  output logic [4:0]            ex_rs,
  output logic [4:0]            ex_rt,
  output logic [4:0]            ex_rd,
  output logic [DATA_WIDTH-1:0] ex_op_a,
  output logic [DATA_WIDTH-1:0] ex_op_b,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic [CTRL_W-1:0]     ex_ctrl
);

  logic                  wb_active;
  logic                  lu_hazard;
  logic                  wb_hazard;
  logic [DATA_WIDTH-1:0] op_a_sel;
  logic [DATA_WIDTH-1:0] op_b_sel;

  assign wb_active = wb_reg_write && (wb_we != 5'd0);
  assign lu_hazard = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                     ((ex_rd == id_rs) || (ex_rd == id_rt));

`ifdef ID_EX_WB_BYPASS_EN
  // wb_active already excludes r0, so index 0 always reads the register file
  assign op_a_sel  = (wb_active && (wb_we == id_rs)) ? wb_data : id_rdata1;
  assign op_b_sel  = (wb_active && (wb_we == id_rt)) ? wb_data : id_rdata2;
  assign wb_hazard = 1'b0;
`else
  // Without the bypass, wait one bubble so the register file holds the new value
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign op_a_sel  = id_rdata1;
  assign op_b_sel  = id_rdata2;
  assign wb_hazard = wb_active && id_valid && ((wb_we == id_rs) || (wb_we == id_rt));
`endif

  assign load_use_stall = !rst && !flush && (lu_hazard || wb_hazard);

  always_ff @(posedge clk) begin
    if (rst || flush || (!hold && load_use_stall)) begin
      ex_valid     <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_imm       <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_ctrl      <= '0;
    end else if (!hold) begin
      ex_valid     <= id_valid;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_rd        <= id_rd;
      ex_op_a      <= op_a_sel;
      ex_op_b      <= op_b_sel;
      ex_imm       <= id_imm;
      ex_reg_write <= id_valid && id_reg_write;
      ex_mem_read  <= id_valid && id_mem_read;
      ex_ctrl      <= id_valid ? id_ctrl : '0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a register-file-level reference model.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int CW = 8;

  typedef struct {
    logic          valid;
    logic [4:0]    rs, rt, rd;
    logic [DW-1:0] a, b, imm;
    logic          rw, mr;
    logic [CW-1:0] ctrl;
  } ex_t;

  logic          clk = 1'b0;
  logic          rst, id_valid, id_reg_write, id_mem_read;
  logic [4:0]    id_rs, id_rt, id_rd, wb_we;
  logic [DW-1:0] id_rdata1, id_rdata2, id_imm, wb_data;
  logic [CW-1:0] id_ctrl;
  logic          wb_reg_write, hold, flush;
  logic          load_use_stall, ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic [DW-1:0] ex_op_a, ex_op_b, ex_imm;
  logic [CW-1:0] ex_ctrl;

  logic [DW-1:0] regs [32];
  ex_t           m;
  logic          last_stall;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] saved_a;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(DW), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_ctrl(id_ctrl),
    .wb_reg_write(wb_reg_write), .wb_we(wb_we), .wb_data(wb_data),
    .hold(hold), .flush(flush), .load_use_stall(load_use_stall),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Hazard rules: a pending load whose destination the ID instruction reads,
  // or (no-bypass build) a writeback landing on a register it reads this cycle.
  function automatic logic model_stall();
    logic s;
    if (rst || flush) return 1'b0;
    s = m.valid && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs || m.rd == id_rt);
`ifndef ID_EX_WB_BYPASS_EN
    if (id_valid && wb_reg_write && wb_we != 0 && (wb_we == id_rs || wb_we == id_rt)) s = 1'b1;
`endif
    return s;
  endfunction

  function automatic logic [DW-1:0] operand(input logic [4:0] r, input logic [DW-1:0] rf);
`ifdef ID_EX_WB_BYPASS_EN
    // newest architectural value: the in-flight writeback wins, r0 is never written
    if (wb_reg_write && wb_we != 0 && wb_we == r) return wb_data;
`endif
    return rf;
  endfunction

  task automatic tick();
    logic es;
    ex_t  nx;
    id_rdata1 = regs[id_rs];
    id_rdata2 = regs[id_rt];
    #1;
    es = model_stall();
    chk("load_use_stall", {63'd0, load_use_stall}, {63'd0, es});
    nx = m;
    if (rst || flush || (!hold && es)) begin
      nx = '{valid: 0, rs: 0, rt: 0, rd: 0, a: 0, b: 0, imm: 0, rw: 0, mr: 0, ctrl: 0};
    end else if (!hold) begin
      nx.valid = id_valid;
      nx.rs = id_rs; nx.rt = id_rt; nx.rd = id_rd;
      nx.a = operand(id_rs, id_rdata1);
      nx.b = operand(id_rt, id_rdata2);
      nx.imm = id_imm;
      nx.rw = id_valid & id_reg_write;
      nx.mr = id_valid & id_mem_read;
      nx.ctrl = id_valid ? id_ctrl : '0;
    end
    @(posedge clk);
    if (wb_reg_write && wb_we != 0) regs[wb_we] = wb_data;
    m = nx;
    last_stall = es;
    #1;
    chk("ex_valid", {63'd0, ex_valid}, {63'd0, m.valid});
    chk("ex_rs", {59'd0, ex_rs}, {59'd0, m.rs});
    chk("ex_rt", {59'd0, ex_rt}, {59'd0, m.rt});
    chk("ex_rd", {59'd0, ex_rd}, {59'd0, m.rd});
    chk("ex_op_a", {32'd0, ex_op_a}, {32'd0, m.a});
    chk("ex_op_b", {32'd0, ex_op_b}, {32'd0, m.b});
    chk("ex_imm", {32'd0, ex_imm}, {32'd0, m.imm});
    chk("ex_reg_write", {63'd0, ex_reg_write}, {63'd0, m.rw});
    chk("ex_mem_read", {63'd0, ex_mem_read}, {63'd0, m.mr});
    chk("ex_ctrl", {56'd0, ex_ctrl}, {56'd0, m.ctrl});
  endtask

  task automatic new_instr();
    id_valid     = ($urandom_range(0, 9) < 8);
    id_rs        = 5'($urandom_range(0, 9));
    id_rt        = 5'($urandom_range(0, 9));
    id_rd        = 5'($urandom_range(0, 9));
    id_imm       = $urandom;
    id_reg_write = 1'($urandom);
    id_mem_read  = ($urandom_range(0, 9) < 4);
    id_ctrl      = 8'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? '0 : $urandom;
    m = '{valid: 0, rs: 0, rt: 0, rd: 0, a: 0, b: 0, imm: 0, rw: 0, mr: 0, ctrl: 0};
    last_stall = 1'b0;
    hold = 0; flush = 0; wb_reg_write = 0; wb_we = 0; wb_data = 0;

    // reset with random ID fields
    rst = 1;
    new_instr();
    tick();
    new_instr();
    tick();
    chk("rst_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_op_a", {32'd0, ex_op_a}, 64'd0);

    // first capture after release
    rst = 0;
    regs[3] = 32'h11;
    id_valid = 1; id_rs = 3; id_rt = 4; id_rd = 6; id_mem_read = 0; id_reg_write = 1;
    tick();
    chk("cap_rs", {59'd0, ex_rs}, 64'd3);
    chk("cap_op_a", {32'd0, ex_op_a}, 64'h11);

    // writeback bypass on rt
    regs[5] = 32'h1;
    id_rs = 1; id_rt = 5; id_rd = 2;
    wb_reg_write = 1; wb_we = 5; wb_data = 32'hDEADBEEF;
`ifdef ID_EX_WB_BYPASS_EN
    tick();
    chk("byp_op_b", {32'd0, ex_op_b}, 64'hDEADBEEF);
`else
    id_rdata2 = regs[id_rt];
    #1 chk("wb_stall", {63'd0, load_use_stall}, 64'd1);
    tick();
    chk("wb_bubble", {63'd0, ex_valid}, 64'd0);
    wb_reg_write = 0;
    tick();
    chk("wb_op_b", {32'd0, ex_op_b}, 64'hDEADBEEF);
    // writeback of rs=9 stalls once, then the new value is read
    id_rs = 9; id_rt = 1;
    wb_reg_write = 1; wb_we = 9; wb_data = 32'hCAFE0009;
    id_rdata1 = regs[id_rs];
    #1 chk("wb9_stall", {63'd0, load_use_stall}, 64'd1);
    tick();
    wb_reg_write = 0;
    tick();
    chk("wb9_op_a", {32'd0, ex_op_a}, 64'hCAFE0009);
`endif
    // r0 is never bypassed
    wb_reg_write = 1; wb_we = 0; wb_data = 32'h55; id_rt = 0; id_rs = 1;
    tick();
    chk("r0_op_b", {32'd0, ex_op_b}, 64'd0);
    wb_reg_write = 0;

    // load-use: load writes r8, next instruction reads r8
    regs[8] = 32'h88;
    id_valid = 1; id_mem_read = 1; id_rd = 8; id_rs = 1; id_rt = 2;
    tick();
    id_rs = 8; id_rt = 3; id_rd = 9; id_mem_read = 0;
    id_rdata1 = regs[id_rs];
    #1 chk("lu_stall", {63'd0, load_use_stall}, 64'd1);
    tick();
    chk("lu_bubble", {63'd0, ex_valid}, 64'd0);
    tick();
    chk("lu_cap_valid", {63'd0, ex_valid}, 64'd1);
    chk("lu_cap_a", {32'd0, ex_op_a}, 64'h88);

    // hold for three cycles, then hold with flush
    hold = 1;
    saved_a = ex_op_a;
    for (int i = 0; i < 3; i++) begin
      new_instr();
      tick();
    end
    chk("hold_op_a", {32'd0, ex_op_a}, {32'd0, saved_a});
    chk("hold_valid", {63'd0, ex_valid}, 64'd1);
    flush = 1;
    tick();
    chk("flush_valid", {63'd0, ex_valid}, 64'd0);
    chk("flush_rw", {63'd0, ex_reg_write}, 64'd0);
    hold = 0; flush = 0;

    // randomized traffic; ID is held by upstream on stall or hold
    for (int c = 0; c < 600; c++) begin
      if (!(last_stall || hold)) new_instr();
      rst          = ($urandom_range(0, 99) < 3);
      flush        = ($urandom_range(0, 99) < 8);
      hold         = ($urandom_range(0, 99) < 15);
      wb_reg_write = ($urandom_range(0, 9) < 5);
      wb_we        = 5'($urandom_range(0, 9));
      wb_data      = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
